// File: rtl/divrem_arbiter_pkg.sv
// Shared definitions for controllers that multiplex clients onto one divrem unit.
// Arbiter state encodings and operand-width derivation.
package divrem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_DLY     = 2'd1,
        ARB_WAIT    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    localparam int DEF_WIDTH_LOG = 4;
    localparam int DEF_NREQ      = 2;

    function automatic int width_of(input int width_log);
        return 1 << width_log;
    endfunction

endpackage

// File: rtl/divrem_arbiter_if.sv
// Requester-side bus of the divrem arbiter: level requests, flattened operands, shared result.
// Slice i of num/den belongs to requester i; rem/error are valid while any done bit is high.
interface divrem_arbiter_if
    import divrem_arbiter_pkg::*;
#(
    parameter int WIDTH_LOG = DEF_WIDTH_LOG,
    parameter int NREQ      = DEF_NREQ
);
    localparam int WIDTH = width_of(WIDTH_LOG);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] num;
    logic [NREQ*WIDTH-1:0] den;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      rem;
    logic                  error;
    logic                  busy;

    modport master (
        output req, num, den,
        input  gnt, done, rem, error, busy
    );

    modport slave (
        input  req, num, den,
        output gnt, done, rem, error, busy
    );

endinterface

// File: rtl/divrem_arbiter_divrem.sv
// Restoring divider returning num % den; flags error immediately when den == 0.
// Latency: ready drops the cycle after go and returns WIDTH cycles later.
// Backpressure: go is ignored while ready is low; the caller waits on ready/error.
module divrem_arbiter_divrem
    import divrem_arbiter_pkg::*;
#(
    parameter int WIDTH_LOG = DEF_WIDTH_LOG
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic [width_of(WIDTH_LOG)-1:0] num,
    input  logic [width_of(WIDTH_LOG)-1:0] den,
    output logic                          ready,
    output logic                          error,
    output logic [width_of(WIDTH_LOG)-1:0] rem
);
    localparam int WIDTH = width_of(WIDTH_LOG);
    localparam int CW    = WIDTH_LOG + 1;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;

    // One restoring step: shift the next dividend bit in and subtract if it fits.
    assign r_sh = {r_q, q_q[WIDTH-1]};
    assign diff = r_sh - {1'b0, d_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b1;
            error <= 1'b0;
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else if (ready && go) begin
            d_q   <= den;
            q_q   <= num;
            r_q   <= '0;
            cnt_q <= CW'(WIDTH);
            error <= (den == '0);
            ready <= (den == '0);
        end else if (!ready) begin
            r_q   <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            q_q   <= {q_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                ready <= 1'b1;
            end
        end
    end

    assign rem = r_q;

endmodule

// File: rtl/divrem_arbiter.sv
// Round-robin arbiter sharing one divrem unit among NREQ requesters.
// Latency: gnt 1 cycle after IDLE sees req; done WIDTH+2 cycles after gnt.
// Backpressure: requests wait as level req; one operation in flight, one IDLE cycle between.
module divrem_arbiter
    import divrem_arbiter_pkg::*;
#(
    parameter int WIDTH_LOG = DEF_WIDTH_LOG,
    parameter int NREQ      = DEF_NREQ
)(
    input  logic             clk,
    input  logic             rst,
    divrem_arbiter_if.slave  bus
);
    localparam int WIDTH = width_of(WIDTH_LOG);
    localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state, state_n;
    logic [NREQ-1:0]  gnt_q, gnt_n;
    logic [NREQ-1:0]  done_q, done_n;
    logic [WIDTH-1:0] rem_q, rem_n;
    logic             err_q, err_n;
    logic             busy_q, busy_n;
    logic             go_q, go_n;
    logic [IDXW-1:0]  ptr_q, ptr_n;
    logic [IDXW-1:0]  idx_q, idx_n;
    logic [IDXW-1:0]  pick;
    logic [WIDTH-1:0] num_r, num_n;
    logic [WIDTH-1:0] den_r, den_n;
    logic             div_ready;
    logic             div_error;
    logic [WIDTH-1:0] div_rem;

    // First requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [IDXW-1:0] p);
        logic [IDXW-1:0] sel;
        logic            found;
        sel   = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            int j;
            j = (int'(p) + off) % NREQ;
            if (!found && r[IDXW'(j)]) begin
                sel   = IDXW'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(bus.req, ptr_q);

    always_comb begin
        state_n = state;
        gnt_n   = gnt_q;
        done_n  = '0;
        rem_n   = rem_q;
        err_n   = err_q;
        busy_n  = busy_q;
        go_n    = 1'b0;
        ptr_n   = ptr_q;
        idx_n   = idx_q;
        num_n   = num_r;
        den_n   = den_r;
        case (state)
            ARB_IDLE: begin
                gnt_n  = '0;
                busy_n = 1'b0;
                if (|bus.req) begin
                    idx_n   = pick;
                    num_n   = bus.num[int'(pick)*WIDTH +: WIDTH];
                    den_n   = bus.den[int'(pick)*WIDTH +: WIDTH];
                    gnt_n   = NREQ'(1) << pick;
                    go_n    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = ARB_DLY;
                end
            end
            ARB_DLY: begin
                state_n = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (div_ready || div_error) begin
                    rem_n   = div_error ? 'x : div_rem;
                    err_n   = div_error;
                    done_n  = gnt_q;
                    ptr_n   = (idx_q == IDXW'(NREQ-1)) ? '0 : idx_q + 1'b1;
                    state_n = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                gnt_n   = '0;
                busy_n  = 1'b0;
                state_n = ARB_IDLE;
            end
            default: begin
                state_n = arb_state_t'('x);
                gnt_n   = 'x;
                done_n  = 'x;
                rem_n   = 'x;
                err_n   = 'x;
                busy_n  = 'x;
                go_n    = 'x;
                ptr_n   = 'x;
                idx_n   = 'x;
                num_n   = 'x;
                den_n   = 'x;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            gnt_q  <= '0;
            done_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            go_q   <= 1'b0;
            ptr_q  <= '0;
            idx_q  <= '0;
            num_r  <= 'x;
            den_r  <= 'x;
        end else begin
            state  <= state_n;
            gnt_q  <= gnt_n;
            done_q <= done_n;
            rem_q  <= rem_n;
            err_q  <= err_n;
            busy_q <= busy_n;
            go_q   <= go_n;
            ptr_q  <= ptr_n;
            idx_q  <= idx_n;
            num_r  <= num_n;
            den_r  <= den_n;
        end
    end

    divrem_arbiter_divrem #(
        .WIDTH_LOG (WIDTH_LOG)
    ) d_m (
        .clk   (clk),
        .rst   (rst),
        .go    (go_q),
        .num   (num_r),
        .den   (den_r),
        .ready (div_ready),
        .error (div_error),
        .rem   (div_rem)
    );

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.rem   = rem_q;
    assign bus.error = err_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_divrem_arbiter.sv
// Bench for divrem_arbiter: directed vector table, multi-cycle corner sequences, randomized traffic.
module tb_divrem_arbiter;
    import divrem_arbiter_pkg::*;

    localparam int WL    = 4;
    localparam int NR    = 2;
    localparam int W     = 16;
    localparam int LIMIT = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divrem_arbiter_if #(.WIDTH_LOG(WL), .NREQ(NR)) bus();

    divrem_arbiter #(.WIDTH_LOG(WL), .NREQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int model_ptr = 0;
    logic [W-1:0] opn [NR];
    logic [W-1:0] opd [NR];

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] n0, d0, n1, d1;
        int           eidx;
        logic [W-1:0] erem;
        logic         eerr;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops;
        for (int i = 0; i < NR; i++) begin
            bus.num[i*W +: W] = opn[i];
            bus.den[i*W +: W] = opd[i];
        end
    endtask

    function automatic int model_pick(input logic [NR-1:0] r, input int p);
        for (int off = 0; off < NR; off++) begin
            int j;
            j = (p + off) % NR;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Waits for a done pulse, drops the served request, and checks the one-cycle pulse and IDLE gap.
    task automatic wait_done(output int idx, output logic [W-1:0] rm, output logic e);
        int n;
        n   = 0;
        idx = -1;
        rm  = '0;
        e   = 1'b0;
        while (bus.done == '0 && n < LIMIT) begin
            tick();
            n++;
        end
        if (bus.done == '0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", LIMIT);
            return;
        end
        chk("done_matches_gnt", 32'(bus.done), 32'(bus.gnt));
        chk("done_onehot", $countones(bus.done), 1);
        for (int i = 0; i < NR; i++) if (bus.done[i]) idx = i;
        rm = bus.rem;
        e  = bus.error;
        bus.req[idx] = 1'b0;
        model_ptr = (idx + 1) % NR;
        tick();
        chk("done_pulse_width", 32'(bus.done), 0);
        chk("busy_idle_gap", 32'(bus.busy), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},   32'(bus.gnt),   0);
        chk({tag, "_done"},  32'(bus.done),  0);
        chk({tag, "_rem"},   32'(bus.rem),   0);
        chk({tag, "_error"}, 32'(bus.error), 0);
        chk({tag, "_busy"},  32'(bus.busy),  0);
    endtask

    initial begin
        int           idx, eidx, prev;
        logic [W-1:0] rm, en, ed;
        logic         e;

        tbl[0] = '{2'b01, 16'd35,    16'd6,     16'd0, 16'd1,     0, 16'd5,   1'b0};
        tbl[1] = '{2'b10, 16'd0,     16'd1,     16'd9, 16'd0,     1, 16'd0,   1'b1};
        tbl[2] = '{2'b10, 16'd0,     16'd1,     16'd17, 16'd5,    1, 16'd2,   1'b0};
        tbl[3] = '{2'b01, 16'd0,     16'd3,     16'd4, 16'd4,     0, 16'd0,   1'b0};
        tbl[4] = '{2'b01, 16'd65535, 16'd1,     16'd4, 16'd4,     0, 16'd0,   1'b0};
        tbl[5] = '{2'b10, 16'd1,     16'd1,     16'd7, 16'd65535, 1, 16'd7,   1'b0};
        tbl[6] = '{2'b01, 16'd65535, 16'd65535, 16'd1, 16'd1,     0, 16'd0,   1'b0};
        tbl[7] = '{2'b10, 16'd1,     16'd1,     16'd65534, 16'd256, 1, 16'd254, 1'b0};
        tbl[8] = '{2'b01, 16'd0,     16'd0,     16'd1, 16'd1,     0, 16'd0,   1'b1};
        tbl[9] = '{2'b01, 16'd1000,  16'd33,    16'd1, 16'd1,     0, 16'd10,  1'b0};

        rst     = 1'b1;
        bus.req = '0;
        opn[0] = '0; opd[0] = 16'd1; opn[1] = '0; opd[1] = 16'd1;
        drive_ops();
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        model_ptr = 0;

        // Simultaneous requests from reset: requester 0 first, then 1.
        opn[0] = 16'd35;  opd[0] = 16'd6;
        opn[1] = 16'd100; opd[1] = 16'd7;
        drive_ops();
        bus.req = 2'b11;
        wait_done(idx, rm, e);
        chk("simul_first_idx", idx, 0);
        chk("simul_first_rem", 32'(rm), 5);
        wait_done(idx, rm, e);
        chk("simul_second_idx", idx, 1);
        chk("simul_second_rem", 32'(rm), 2);
        chk("simul_second_err", 32'(e), 0);

        // Directed single-request vectors.
        for (int t = 0; t < 10; t++) begin
            opn[0] = tbl[t].n0; opd[0] = tbl[t].d0;
            opn[1] = tbl[t].n1; opd[1] = tbl[t].d1;
            drive_ops();
            bus.req = tbl[t].req;
            tick();
            chk("vec_gnt", 32'(bus.gnt), 32'(tbl[t].req));
            chk("vec_busy", 32'(bus.busy), 1);
            wait_done(idx, rm, e);
            chk("vec_idx", idx, tbl[t].eidx);
            chk("vec_error", 32'(e), 32'(tbl[t].eerr));
            if (!tbl[t].eerr) chk("vec_rem", 32'(rm), 32'(tbl[t].erem));
        end

        // Operands changed after grant must not affect the running operation.
        opn[0] = 16'd35; opd[0] = 16'd6;
        drive_ops();
        bus.req = 2'b01;
        tick();
        chk("opchg_gnt", 32'(bus.gnt), 1);
        tick();
        tick();
        opn[0] = 16'd36;
        drive_ops();
        wait_done(idx, rm, e);
        chk("opchg_rem", 32'(rm), 5);

        // Reset while the divider is working: no done, outputs cleared, request re-served.
        opn[0] = 16'd35; opd[0] = 16'd6;
        drive_ops();
        bus.req = 2'b01;
        tick();
        tick();
        tick();
        chk("midrst_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        model_ptr = 0;
        wait_done(idx, rm, e);
        chk("midrst_reserve_idx", idx, 0);
        chk("midrst_reserve_rem", 32'(rm), 5);

        // Fairness: both requesters re-request right after each done.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_ptr = 0;
        prev = -1;
        for (int i = 0; i < NR; i++) begin
            opn[i] = W'($urandom);
            opd[i] = W'($urandom_range(1, 300));
        end
        drive_ops();
        bus.req = 2'b11;
        for (int op = 0; op < 6; op++) begin
            en = opn[op % NR];
            ed = opd[op % NR];
            wait_done(idx, rm, e);
            chk("fair_idx", idx, op % NR);
            chk("fair_no_repeat", 32'(idx != prev), 1);
            chk("fair_rem", 32'(rm), 32'(en % ed));
            prev = idx;
            if (idx >= 0) begin
                opn[idx] = W'($urandom);
                opd[idx] = W'($urandom_range(1, 300));
                drive_ops();
                bus.req[idx] = 1'b1;
            end
        end
        wait_done(idx, rm, e);
        wait_done(idx, rm, e);

        // Randomized traffic against the round-robin / modulo reference model.
        for (int op = 0; op < 40; op++) begin
            for (int i = 0; i < NR; i++) begin
                if (!bus.req[i] && $urandom_range(0, 1) == 1) begin
                    opn[i] = W'($urandom);
                    case ($urandom_range(0, 7))
                        0:       opd[i] = '0;
                        1, 2:    opd[i] = W'($urandom_range(1, 15));
                        default: opd[i] = W'($urandom_range(1, 65535));
                    endcase
                    bus.req[i] = 1'b1;
                end
            end
            if (bus.req == '0) begin
                int b;
                b = $urandom_range(0, NR-1);
                opn[b] = W'($urandom);
                opd[b] = W'($urandom_range(1, 65535));
                bus.req[b] = 1'b1;
            end
            drive_ops();
            eidx = model_pick(bus.req, model_ptr);
            en = opn[eidx];
            ed = opd[eidx];
            wait_done(idx, rm, e);
            chk("rand_idx", idx, eidx);
            chk("rand_error", 32'(e), 32'(ed == '0));
            if (ed != '0) chk("rand_rem", 32'(rm), 32'(en % ed));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
